branch_decision_unit: RTL and testbench

//  Consumer side of the operand comparison used for conditional branches in the multicycle core.

---
 rtl/branch_decision_unit.sv | 142 ++++++++++++++
 tb/tb_branch_decision_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/branch_decision_unit.sv
// Iterative MSB-first operand comparator that resolves conditional branches and next PC.
// Optional macro BDU_EARLY_EXIT_EN ends the compare at the first differing chunk.
module branch_decision_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] rd1_i,
  input  logic [WIDTH-1:0] rd2_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] imm_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             taken_o,
  output logic [WIDTH-1:0] next_pc_o,
  output logic             err_o
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("branch_decision_unit: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             decided;
  logic             lt;

  logic [2:0]       f3_q;
  logic [WIDTH-1:0] a_q, b_q, pc_q, imm_q;

  logic [CHUNK-1:0] ca, cb;
  logic             c_ne, c_lt, decided_nx, lt_nx, fin;
  logic             res_taken, res_err;
  logic [WIDTH-1:0] res_pc;

  function automatic logic is_signed_cmp(input logic [2:0] f3);
    return f3[2:1] == 2'b10;
  endfunction

  function automatic logic is_illegal(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction

  function automatic logic decide(input logic [2:0] f3, input logic eq, input logic lt_v);
    case (f3)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return lt_v;
      3'b101:  return !lt_v;
      3'b110:  return lt_v;
      3'b111:  return !lt_v;
      default: return 1'b0;
    endcase
  endfunction

  // Chunk compare stage: the sign bit is flipped on the MSB chunk so an unsigned
  // compare of the biased values yields the signed ordering.
  always_comb begin
    ca = a_q[idx*CHUNK +: CHUNK];
    cb = b_q[idx*CHUNK +: CHUNK];
    if (is_signed_cmp(f3_q) && idx == IDX_W'(N-1)) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
    c_ne       = ca != cb;
    c_lt       = ca < cb;
    decided_nx = decided | c_ne;
    lt_nx      = (!decided && c_ne) ? c_lt : lt;
`ifdef BDU_EARLY_EXIT_EN
    fin        = (idx == '0) || (!decided && c_ne);
`else
    fin        = (idx == '0);
`endif
    res_err    = is_illegal(f3_q);
    res_taken  = !res_err && decide(f3_q, !decided_nx, lt_nx);
    res_pc     = res_taken ? (pc_q + imm_q) : (pc_q + WIDTH'(4));
  end

  // Operand capture: only control state is reset; these are plain data copies.
  always_ff @(posedge clk) begin
    if (state == IDLE && start_i) begin
      f3_q  <= funct3_i;
      a_q   <= rd1_i;
      b_q   <= rd2_i;
      pc_q  <= pc_i;
      imm_q <= imm_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= IDX_W'(N-1);
      decided   <= 1'b0;
      lt        <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      taken_o   <= 1'b0;
      err_o     <= 1'b0;
      next_pc_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            idx     <= IDX_W'(N-1);
            decided <= 1'b0;
            lt      <= 1'b0;
            busy_o  <= 1'b1;
            state   <= CMP;
          end
        end
        CMP: begin
          decided <= decided_nx;
          lt      <= lt_nx;
          idx     <= idx - IDX_W'(1);
          if (fin) begin
            taken_o   <= res_taken;
            err_o     <= res_err;
            next_pc_o <= res_pc;
            done_o    <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_decision_unit.sv
// Directed scoreboard bench for branch_decision_unit (default WIDTH=32, CHUNK=8).
// Expected latency follows BDU_EARLY_EXIT_EN when the bench is built with it.
module tb_branch_decision_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rd1 = '0, rd2 = '0, pc = '0, imm = '0;
  logic        busy, done, taken, err;
  logic [31:0] next_pc;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        taken;
    logic [31:0] next_pc;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  branch_decision_unit dut (
    .clk(clk), .rst(rst), .start_i(start), .funct3_i(funct3),
    .rd1_i(rd1), .rd2_i(rd2), .pc_i(pc), .imm_i(imm),
    .busy_o(busy), .done_o(done), .taken_o(taken),
    .next_pc_o(next_pc), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] p, input logic [31:0] im);
    exp_t e;
    logic [31:0] ta, tb_v;
    e.err = 1'b0;
    case (f3)
      3'b000:  e.taken = (a == b);
      3'b001:  e.taken = (a != b);
      3'b100:  e.taken = ($signed(a) < $signed(b));
      3'b101:  e.taken = ($signed(a) >= $signed(b));
      3'b110:  e.taken = (a < b);
      3'b111:  e.taken = (a >= b);
      default: begin e.taken = 1'b0; e.err = 1'b1; end
    endcase
    e.next_pc = e.taken ? (p + im) : (p + 32'd4);
    e.lat = 5;
`ifdef BDU_EARLY_EXIT_EN
    ta = a;
    tb_v = b;
    for (int k = 1; k <= 4; k++) begin
      if (ta[31:24] != tb_v[31:24]) begin
        e.lat = k + 1;
        break;
      end
      ta = ta << 8;
      tb_v = tb_v << 8;
    end
`else
    ta = a;
    tb_v = b;
`endif
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] p, input logic [31:0] im,
                        input bit hold);
    exp_t e;
    int edges;
    sb.push_back(model(f3, a, b, p, im));
    @(negedge clk);
    funct3 = f3; rd1 = a; rd2 = b; pc = p; imm = im; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    rd1 = $urandom; rd2 = $urandom; pc = $urandom; imm = $urandom; funct3 = 3'($urandom);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    edges = 0;
    while (!done && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(edges + 1), 64'(e.lat));
    check({tag, "_taken"}, 64'(taken), 64'(e.taken));
    check({tag, "_next_pc"}, 64'(next_pc), 64'(e.next_pc));
    check({tag, "_err"}, 64'(err), 64'(e.err));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
    check({tag, "_held"}, {31'd0, err, next_pc, taken}, {31'd0, e.err, e.next_pc, e.taken});
  endtask

  initial begin
    int pulses;
    #2;
    check("reset_state", {29'd0, busy, done, taken, err, next_pc}, 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op("beq_eq", 3'b000, 32'h12345678, 32'h12345678, 32'h100, 32'h20, 1'b0);
    run_op("blt", 3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h400, 32'h80, 1'b0);
    run_op("bltu", 3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h400, 32'h80, 1'b0);
    run_op("bge", 3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h500, 32'hFFFFFFF0, 1'b0);
    run_op("bgeu", 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h500, 32'hFFFFFFF0, 1'b0);
    run_op("illegal", 3'b010, 32'h1, 32'h2, 32'h200, 32'h40, 1'b0);
    run_op("bne_clr", 3'b001, 32'h5, 32'h6, 32'h300, 32'h8, 1'b0);
    run_op("illegal3", 3'b011, 32'h7, 32'h7, 32'h600, 32'h40, 1'b0);
    run_op("beq_lsb", 3'b000, 32'h12345678, 32'h12345679, 32'hFFFFFFFC, 32'h40, 1'b0);
    run_op("blt_mid", 3'b100, 32'h00120000, 32'h00340000, 32'h700, 32'h10, 1'b0);

    // Abort an operation with an asynchronous reset two cycles in.
    @(negedge clk);
    funct3 = 3'b000; rd1 = 32'h1; rd2 = 32'h1; pc = 32'h800; imm = 32'h4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; #1;
    check("rst_abort", {29'd0, busy, done, taken, err, next_pc}, 64'd0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("rst_no_done", 64'(pulses), 64'd0);

    run_op("beq_after_rst", 3'b000, 32'hCAFEBABE, 32'hCAFEBABE, 32'h100, 32'h20, 1'b0);
    run_op("bne_hold", 3'b001, 32'hA0000000, 32'h00000000, 32'hFFFFFFF0, 32'h10, 1'b1);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
